// File: rtl/mlp_pkg.sv
// Shared types and default sizing for the MLP host-side command sequencer.
package mlp_pkg;

  localparam int DEF_RUN_W   = 8;
  localparam int DEF_TIMEOUT = 4096;
  localparam int DEF_TO_W    = 13;

  typedef enum logic [2:0] {
    IDLE,
    INIT_REQ,
    START_REQ,
    WAIT_RESULT,
    DONE,
    ERR
  } seq_state_e;

  // States in which the sequencer is waiting on the FSM and the phase timer runs.
  function automatic logic is_wait_state(seq_state_e s);
    return (s == INIT_REQ) || (s == START_REQ) || (s == WAIT_RESULT);
  endfunction

endpackage

// File: rtl/mlp_host_seq_if.sv
// Handshake bundle between the host sequencer (master) and the MLP control FSM (slave).
interface mlp_host_seq_if;

  logic init_valid;
  logic init_ready;
  logic start_valid;
  logic start_ready;
  logic result_valid;

  modport master (
    output init_valid,
    output start_valid,
    input  init_ready,
    input  start_ready,
    input  result_valid
  );

  modport slave (
    input  init_valid,
    input  start_valid,
    output init_ready,
    output start_ready,
    output result_valid
  );

endinterface

// File: rtl/mlp_phase_timer.sv
// Saturating per-phase cycle counter; flags the cycle whose closing edge reaches TIMEOUT.
module mlp_phase_timer
  import mlp_pkg::*;
#(
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [TO_W-1:0] LIMIT = TO_W'(TIMEOUT);
  localparam logic [TO_W-1:0] LAST  = TO_W'(TIMEOUT - 1);

  logic [TO_W-1:0] count_q;

  // Count cycles spent in the current waiting phase, holding at LIMIT.
  always_ff @(posedge clk_i) begin
    // NOTE: sequential state is written with non-blocking assignments so every
    // flop samples the pre-edge values regardless of statement order.
    if (rst_i || clr) begin
      count_q <= '0;
    end else if (en && (count_q != LIMIT)) begin
      count_q <= count_q + 1'b1;
    end
  end

  // High while the phase has lasted TIMEOUT-1 cycles: the next edge completes TIMEOUT.
  assign expired = en && (count_q >= LAST);

endmodule

// File: rtl/mlp_host_seq.sv
// Host command sequencer: runs an optional init plus N inference handshakes against the MLP FSM.
module mlp_host_seq
  import mlp_pkg::*;
#(
  parameter int RUN_W   = DEF_RUN_W,
  parameter int TIMEOUT = DEF_TIMEOUT,
  parameter int TO_W    = DEF_TO_W
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             cmd_valid_i,
  output logic             cmd_ready_o,
  input  logic             cmd_init_i,
  input  logic [RUN_W-1:0] cmd_runs_i,
  mlp_host_seq_if.master   fsm,
  output logic             busy_o,
  output logic             done_o,
  output logic [RUN_W-1:0] runs_done_o,
  output logic             err_timeout_o,
  output logic             err_spurious_o
);

  seq_state_e       state_q;
  seq_state_e       state_d;
  logic [RUN_W-1:0] runs_q;
  logic [RUN_W-1:0] runs_done_q;
  logic [RUN_W-1:0] run_next;
  logic             err_timeout_q;
  logic             err_spurious_q;
  logic             cmd_xfer;
  logic             result_hit;
  logic             expired;

  assign cmd_xfer   = cmd_valid_i && cmd_ready_o;
  assign result_hit = (state_q == WAIT_RESULT) && fsm.result_valid;
  assign run_next   = runs_done_q + 1'b1;

  mlp_phase_timer #(
    .TIMEOUT(TIMEOUT),
    .TO_W   (TO_W)
  ) u_timer (
    .clk_i  (clk_i),
    .rst_i  (rst_i),
    .clr    (state_d != state_q),
    .en     (is_wait_state(state_q)),
    .expired(expired)
  );

  // State register.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic; a transfer or result in the expiry cycle takes priority over ERR.
  always_comb begin
    // NOTE: the default assignment up front keeps every path assigned, so no latch is inferred.
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (cmd_xfer) begin
          if (cmd_init_i)             state_d = INIT_REQ;
          else if (cmd_runs_i != '0)  state_d = START_REQ;
          else                        state_d = DONE;
        end
      end
      INIT_REQ: begin
        if (fsm.init_ready)  state_d = (runs_q != '0) ? START_REQ : DONE;
        else if (expired)    state_d = ERR;
      end
      START_REQ: begin
        if (fsm.start_ready) state_d = WAIT_RESULT;
        else if (expired)    state_d = ERR;
      end
      WAIT_RESULT: begin
        if (fsm.result_valid) state_d = (run_next == runs_q) ? DONE : START_REQ;
        else if (expired)     state_d = ERR;
      end
      DONE:    state_d = IDLE;
      ERR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Outputs decoded from the registered state only, so valids never follow ready combinationally.
  always_comb begin
    cmd_ready_o     = (state_q == IDLE) && !rst_i;
    fsm.init_valid  = (state_q == INIT_REQ);
    fsm.start_valid = (state_q == START_REQ);
    done_o          = (state_q == DONE);
    busy_o          = (state_q != IDLE);
  end

  // Command latch, completed-run counter and sticky error flags.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      runs_q         <= '0;
      runs_done_q    <= '0;
      err_timeout_q  <= 1'b0;
      err_spurious_q <= 1'b0;
    end else begin
      if (cmd_xfer) begin
        runs_q         <= cmd_runs_i;
        runs_done_q    <= '0;
        err_timeout_q  <= 1'b0;
        err_spurious_q <= 1'b0;
      end
      if (result_hit) begin
        runs_done_q <= run_next;
      end
      if (state_d == ERR) begin
        err_timeout_q <= 1'b1;
      end
      if (fsm.result_valid && (state_q != WAIT_RESULT)) begin
        err_spurious_q <= 1'b1;
      end
    end
  end

  assign runs_done_o    = runs_done_q;
  assign err_timeout_o  = err_timeout_q;
  assign err_spurious_o = err_spurious_q;

endmodule
